dct8_pipe: RTL and testbench

//  Pipelined, parametrised 8-point 1-D forward DCT row/column engine for the JPEG path.

---
 rtl/dct8_pipe_if.sv | 23 ++
 rtl/dct8_pipe.sv | 173 +++++++++++++++++
 tb/tb_dct8_pipe.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dct8_pipe_if.sv
// Streaming bundle for dct8_pipe: the input vector channel and the result channel.
// The engine takes the slave view; the producer/consumer side takes the master view.
interface dct8_pipe_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12
);
  logic                 in_valid;
  logic                 in_ready;
  logic [8*IN_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*OUT_W-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dct8_pipe.sv
// Four-stage pipelined 8-point forward DCT with a global stall and saturating output.
// Optional macro DCT_ROUND_EN: round-half-up in the final scale; otherwise floor.
module dct8_pipe #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 12,
  parameter int COEF_FRAC = 12
) (
  input  logic      clk,
  input  logic      rst,
  dct8_pipe_if.slave bus
);

  localparam int SW = IN_W + 2;
  localparam int EW = IN_W + 3;
  localparam int AW = IN_W + COEF_FRAC + 6;

  // Reference constants are held at 24 fractional bits and rounded to COEF_FRAC.
  function automatic longint scale_coef(input longint k24);
    if (COEF_FRAC >= 24)
      return k24 <<< (COEF_FRAC - 24);
    else
      return (k24 + (64'sd1 <<< (23 - COEF_FRAC))) >>> (24 - COEF_FRAC);
  endfunction

  localparam logic signed [AW-1:0] K1 = AW'(scale_coef(64'sd8227423));
  localparam logic signed [AW-1:0] K2 = AW'(scale_coef(64'sd7750063));
  localparam logic signed [AW-1:0] K3 = AW'(scale_coef(64'sd6974873));
  localparam logic signed [AW-1:0] K4 = AW'(scale_coef(64'sd5931642));
  localparam logic signed [AW-1:0] K5 = AW'(scale_coef(64'sd4660461));
  localparam logic signed [AW-1:0] K6 = AW'(scale_coef(64'sd3210181));
  localparam logic signed [AW-1:0] K7 = AW'(scale_coef(64'sd1636536));

  localparam logic signed [AW-1:0] OUT_MAX = (AW'(1) <<< (OUT_W - 1)) - AW'(1);
  localparam logic signed [AW-1:0] OUT_MIN = -OUT_MAX - AW'(1);
  localparam logic signed [AW-1:0] RND     = AW'(1) <<< (COEF_FRAC - 1);

  genvar gi;

  logic adv;
  logic v1_reg, v2_reg, v3_reg, v4_reg;

  logic signed [SW-1:0] s1_reg  [4];
  logic signed [SW-1:0] d1_reg  [4];
  logic signed [SW-1:0] s1_next [4];
  logic signed [SW-1:0] d1_next [4];

  logic signed [EW-1:0] e2_reg  [4];
  logic signed [EW-1:0] e2_next [4];
  logic signed [SW-1:0] o2_reg  [4];

  logic signed [AW-1:0] ea [4];
  logic signed [AW-1:0] da [4];
  logic signed [AW-1:0] acc3_reg  [8];
  logic signed [AW-1:0] acc3_next [8];

  logic [OUT_W-1:0] y4_reg  [8];
  logic [OUT_W-1:0] y4_next [8];

  // One stall signal freezes every stage, so order and output stability come for free.
  assign adv           = !v4_reg || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v4_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
      v4_reg <= 1'b0;
    end else if (adv) begin
      v1_reg <= bus.in_valid;
      v2_reg <= v1_reg;
      v3_reg <= v2_reg;
      v4_reg <= v3_reg;
    end
  end

  // S1: mirror butterfly on zero-extended unsigned samples.
  for (gi = 0; gi < 4; gi++) begin : g_s1
    logic signed [SW-1:0] xa;
    logic signed [SW-1:0] xb;
    assign xa = {2'b00, bus.in_data[(8-gi)*IN_W-1 -: IN_W]};
    assign xb = {2'b00, bus.in_data[(gi+1)*IN_W-1 -: IN_W]};
    assign s1_next[gi] = xa + xb;
    assign d1_next[gi] = xa - xb;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_reg[gi] <= '0;
        d1_reg[gi] <= '0;
      end else if (adv) begin
        s1_reg[gi] <= s1_next[gi];
        d1_reg[gi] <= d1_next[gi];
      end
    end
  end

  // S2: even-half butterfly; odd differences ride along untouched.
  assign e2_next[0] = EW'(s1_reg[0]) + EW'(s1_reg[3]);
  assign e2_next[1] = EW'(s1_reg[1]) + EW'(s1_reg[2]);
  assign e2_next[2] = EW'(s1_reg[0]) - EW'(s1_reg[3]);
  assign e2_next[3] = EW'(s1_reg[1]) - EW'(s1_reg[2]);

  for (gi = 0; gi < 4; gi++) begin : g_s2
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        e2_reg[gi] <= '0;
        o2_reg[gi] <= '0;
      end else if (adv) begin
        e2_reg[gi] <= e2_next[gi];
        o2_reg[gi] <= d1_reg[gi];
      end
    end
    assign ea[gi] = AW'(e2_reg[gi]);
    assign da[gi] = AW'(o2_reg[gi]);
  end

  // S3: full-precision constant products; the accumulator is wide enough for every sum.
  always_comb begin
    for (int i = 0; i < 8; i++) acc3_next[i] = '0;
    acc3_next[0] = K4 * (ea[0] + ea[1]);
    acc3_next[4] = K4 * (ea[0] - ea[1]);
    acc3_next[2] = K2 * ea[2] + K6 * ea[3];
    acc3_next[6] = K6 * ea[2] - K2 * ea[3];
    acc3_next[1] = K1 * da[0] + K3 * da[1] + K5 * da[2] + K7 * da[3];
    acc3_next[3] = K3 * da[0] - K7 * da[1] - K1 * da[2] - K5 * da[3];
    acc3_next[5] = K5 * da[0] - K1 * da[1] + K7 * da[2] + K3 * da[3];
    acc3_next[7] = K7 * da[0] - K5 * da[1] + K3 * da[2] - K1 * da[3];
  end

  for (gi = 0; gi < 8; gi++) begin : g_s3
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        acc3_reg[gi] <= '0;
      else if (adv)
        acc3_reg[gi] <= acc3_next[gi];
    end
  end

  // S4: scale back to integer units and clamp into the signed output range.
  for (gi = 0; gi < 8; gi++) begin : g_s4
    logic signed [AW-1:0] rnd_val;
    logic signed [AW-1:0] shr_val;
`ifdef DCT_ROUND_EN
    assign rnd_val = acc3_reg[gi] + RND;
`else
    assign rnd_val = acc3_reg[gi];
`endif
    assign shr_val = rnd_val >>> COEF_FRAC;

    always_comb begin
      y4_next[gi] = shr_val[OUT_W-1:0];
      if (shr_val > OUT_MAX)
        y4_next[gi] = OUT_MAX[OUT_W-1:0];
      else if (shr_val < OUT_MIN)
        y4_next[gi] = OUT_MIN[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        y4_reg[gi] <= '0;
      else if (adv)
        y4_reg[gi] <= y4_next[gi];
    end

    assign bus.out_data[(8-gi)*OUT_W-1 -: OUT_W] = y4_reg[gi];
  end

  // RND is only consumed by the rounding build.
  logic unused_rnd;
  assign unused_rnd = ^RND;

endmodule

// File: tb/tb_dct8_pipe.sv
// Directed and randomised-handshake bench for dct8_pipe (defaults) plus an OUT_W=8 instance.
// A cycle model tracks stage occupancy; expected coefficients come from the direct DCT sum.
module tb_dct8_pipe;

  logic clk;
  logic rst;

  dct8_pipe_if #(.IN_W(8), .OUT_W(12)) bus ();
  dct8_pipe_if #(.IN_W(8), .OUT_W(8))  bus8 ();

  dct8_pipe #(.IN_W(8), .OUT_W(12), .COEF_FRAC(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dct8_pipe #(.IN_W(8), .OUT_W(8), .COEF_FRAC(12)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_obs    = 0;

  logic        mv [4];
  logic [95:0] md [4];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Direct-form DCT with integer constants, followed by scale and clamp to 12 bits.
  function automatic logic [95:0] ref_dct(input logic [63:0] v);
    int          ctab [0:8];
    longint      acc;
    longint      sh;
    int          a;
    int          sgn;
    logic [95:0] r;
    ctab = '{1448, 2009, 1892, 1703, 1448, 1138, 784, 400, 0};
    r = '0;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int n = 0; n < 8; n++) begin
        a = ((2 * n + 1) * k) % 32;
        if (a > 16) a = 32 - a;
        sgn = 1;
        if (a > 8) begin
          a   = 16 - a;
          sgn = -1;
        end
        acc += longint'(v[(8-n)*8-1 -: 8]) * longint'(sgn * ctab[a]);
      end
`ifdef DCT_ROUND_EN
      acc += 2048;
`endif
      sh = acc >>> 12;
      if (sh > 2047) sh = 2047;
      else if (sh < -2048) sh = -2048;
      r[(8-k)*12-1 -: 12] = sh[11:0];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
  endtask

  // One clock of stimulus on the default instance, checked against the occupancy model.
  task automatic cycle(input logic iv, input logic [63:0] idat, input logic ordy);
    logic madv;
    logic obs;
    bus.in_valid  = iv;
    bus.in_data   = idat;
    bus.out_ready = ordy;
    #1;
    madv = !mv[3] || ordy;
    check("in_ready", 96'(bus.in_ready), 96'(madv));
    check("out_valid", 96'(bus.out_valid), 96'(mv[3]));
    if (mv[3]) check("out_data", bus.out_data, md[3]);
    obs = bus.out_valid && ordy;
    @(posedge clk);
    if (madv) begin
      for (int i = 3; i > 0; i--) begin
        mv[i] = mv[i-1];
        md[i] = md[i-1];
      end
      mv[0] = iv;
      md[0] = ref_dct(idat);
    end
    if (iv && madv) n_acc++;
    if (obs) n_obs++;
    #1;
  endtask

  logic [95:0] exp1;
  logic [95:0] exp2;
  int          lat;

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.out_ready = 1'b1;
    model_clear();
    #1;
    check("rst_out_valid", 96'(bus.out_valid), 96'(0));
    check("rst_in_ready", 96'(bus.in_ready), 96'(1));
    check("rst_out_data", bus.out_data, 96'(0));
    check("rst_out_data8", 96'(bus8.out_data), 96'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Flat input of 100: only the DC term survives.
`ifdef DCT_ROUND_EN
    exp1 = {12'd283, 84'd0};
`else
    exp1 = {12'd282, 84'd0};
`endif
    cycle(1'b1, {8{8'd100}}, 1'b1);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      cycle(1'b0, 64'd0, 1'b1);
      lat++;
    end
    check("t1_latency", 96'(lat), 96'(4));
    check("t1_data", bus.out_data, exp1);
    cycle(1'b0, 64'd0, 1'b1);

    // Single impulse at x0 exercises every basis function.
`ifdef DCT_ROUND_EN
    exp2 = {12'd90, 12'd125, 12'd118, 12'd106, 12'd90, 12'd71, 12'd49, 12'd25};
`else
    exp2 = {12'd90, 12'd125, 12'd117, 12'd106, 12'd90, 12'd70, 12'd48, 12'd24};
`endif
    cycle(1'b1, {8'd255, 56'd0}, 1'b1);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      cycle(1'b0, 64'd0, 1'b1);
      lat++;
    end
    check("t2_latency", 96'(lat), 96'(4));
    check("t2_data", bus.out_data, exp2);
    cycle(1'b0, 64'd0, 1'b1);

    // Narrow output instance: DC of a full-scale block must clamp to +127.
    bus8.in_valid = 1'b1;
    bus8.in_data  = {8{8'd255}};
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("t3_early_valid", 96'(bus8.out_valid), 96'(0));
    @(posedge clk);
    #1;
    check("t3_valid", 96'(bus8.out_valid), 96'(1));
    check("t3_data", 96'(bus8.out_data), 96'({8'd127, 56'd0}));

    // Random traffic under random back-pressure.
    n_acc = 0;
    n_obs = 0;
    for (int c = 0; c < 300; c++) begin
      if (n_acc >= 10 && !mv[0] && !mv[1] && !mv[2] && !mv[3]) break;
      cycle((n_acc < 10) ? 1'($urandom_range(0, 1)) : 1'b0,
            {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    check("t4_retired", 96'(n_obs), 96'(10));

    // Reset with three vectors in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, {$urandom, $urandom}, 1'b1);
    cycle(1'b0, 64'd0, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 96'(bus.out_valid), 96'(0));
    check("t5_rst_ready", 96'(bus.in_ready), 96'(1));
    check("t5_rst_data", bus.out_data, 96'(0));
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_post_ready", 96'(bus.in_ready), 96'(1));
    for (int i = 0; i < 5; i++) cycle(1'b0, 64'd0, 1'b1);
    cycle(1'b1, {8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255}, 1'b1);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      cycle(1'b0, 64'd0, 1'b1);
      lat++;
    end
    check("t5_latency", 96'(lat), 96'(4));
    cycle(1'b0, 64'd0, 1'b1);

    // Back-to-back streaming at full rate.
    n_obs = 0;
    for (int i = 0; i < 64; i++) cycle(1'b1, {$urandom, $urandom}, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 64'd0, 1'b1);
    check("t6_retired", 96'(n_obs), 96'(64));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
